pid_setpoint_ramper: RTL and testbench



---
 rtl/pid_ramp_pkg.sv | 20 ++
 rtl/pid_setpoint_ramper_if.sv | 23 ++
 rtl/sys_bus_wr_master.sv | 64 ++++++
 rtl/pid_setpoint_ramper.sv | 203 ++++++++++++++++++++
 tb/tb_pid_setpoint_ramper.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_ramp_pkg.sv
// Shared types and default constants for the PID setpoint ramp sequencer.
// Contents: sequencer state enum, default PID register addresses, and the
// integrator-reset mask written to the configuration register.
package pid_ramp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IRST_SET = 3'd1,
        ST_IRST_CLR = 3'd2,
        ST_STEP     = 3'd3,
        ST_WRITE    = 3'd4,
        ST_WAIT     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [31:0] SP_ADDR_DEF   = 32'h0000_0010;
    localparam logic [31:0] CFG_ADDR_DEF  = 32'h0000_0000;
    localparam logic [31:0] IRST_MASK_DEF = 32'h0000_000E;

endpackage

// File: rtl/pid_setpoint_ramper_if.sv
// sys register bus: single-beat address/data with write/read strobes,
// completed by ack or err from the slave.
// Ports: master drives addr/wdata/wen/ren, slave returns ack/err.
interface pid_setpoint_ramper_if;

    logic [31:0] sys_addr_o;
    logic [31:0] sys_wdata_o;
    logic        sys_wen_o;
    logic        sys_ren_o;
    logic        sys_ack_i;
    logic        sys_err_i;

    modport master (
        output sys_addr_o, sys_wdata_o, sys_wen_o, sys_ren_o,
        input  sys_ack_i, sys_err_i
    );

    modport slave (
        input  sys_addr_o, sys_wdata_o, sys_wen_o, sys_ren_o,
        output sys_ack_i, sys_err_i
    );

endinterface

// File: rtl/sys_bus_wr_master.sv
// Single-write engine for the sys bus: strobe, address/data hold, ack timeout.
// Latency: strobe the cycle after req_i; done_o/err_o combinational on the completing cycle.
// Backpressure: none accepted; holds the transaction until ack, err or timeout.
// Ports: clk_i/rstn_i, req_i + addr_i/data_i (request), done_o/err_o (completion),
//        bus (sys master modport).
module sys_bus_wr_master #(
    parameter int unsigned TMO = 255
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          req_i,
    input  logic [31:0]                   addr_i,
    input  logic [31:0]                   data_i,
    output logic                          done_o,
    output logic                          err_o,
    pid_setpoint_ramper_if.master         bus
);

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    logic        r_busy;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;
    logic        w_tmo;

    // r_cnt is 0 in the strobe cycle, so the TMO-th cycle of the window
    // is the last one in which an ack is still accepted.
    assign w_tmo  = r_busy && (r_cnt == TMO_LAST) && !bus.sys_ack_i;
    assign done_o = r_busy && bus.sys_ack_i && !bus.sys_err_i;
    assign err_o  = r_busy && (bus.sys_err_i || w_tmo);

    assign bus.sys_addr_o  = r_addr;
    assign bus.sys_wdata_o = r_wdata;
    assign bus.sys_wen_o   = r_wen;
    assign bus.sys_ren_o   = 1'b0;

    // A new request may arrive on the same edge the previous one completes,
    // so req_i takes priority over the completion bookkeeping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_busy  <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else if (req_i) begin
            r_busy  <= 1'b1;
            r_wen   <= 1'b1;
            r_addr  <= addr_i;
            r_wdata <= data_i;
            r_cnt   <= '0;
        end else begin
            r_wen <= 1'b0;
            if (done_o || err_o) begin
                r_busy <= 1'b0;
            end else if (r_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/pid_setpoint_ramper.sv
// Ramps the PID setpoint toward a target in rate-limited steps, optionally clearing integrators first.
// Latency: busy the cycle after start; first strobe 1 cycle (irst) or 2 cycles after start.
// Backpressure: waits for ack on every write; abort honoured only at transaction boundaries.
// Ports: clk_i/rstn_i; start_i/abort_i + target_i/step_i/interval_i/irst_i (command);
//        busy_o/done_o/err_o/sp_o (status); bus (sys master modport).
module pid_setpoint_ramper
    import pid_ramp_pkg::*;
#(
    parameter int unsigned DW        = 14,
    parameter logic [31:0] SP_ADDR   = SP_ADDR_DEF,
    parameter logic [31:0] CFG_ADDR  = CFG_ADDR_DEF,
    parameter logic [31:0] IRST_MASK = IRST_MASK_DEF,
    parameter int unsigned TMO       = 255
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DW-1:0]         target_i,
    input  logic [DW-1:0]         step_i,
    input  logic [31:0]           interval_i,
    input  logic                  irst_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DW-1:0]         sp_o,
    pid_setpoint_ramper_if.master bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [DW-1:0]  r_target;
    logic signed [DW-1:0]  r_sp;
    logic signed [DW-1:0]  r_next;
    logic        [DW-1:0]  r_step;
    logic        [31:0]    r_interval;
    logic        [31:0]    r_wait_cnt;
    logic                  r_err;

    logic                  w_start_acc;
    logic                  w_req;
    logic        [31:0]    w_req_addr;
    logic        [31:0]    w_req_data;
    logic                  w_wr_done;
    logic                  w_wr_err;

    // Step arithmetic in DW+1 bits so target - sp cannot overflow.
    logic signed [DW:0]    w_sp_x;
    logic signed [DW:0]    w_tgt_x;
    logic signed [DW:0]    w_step_x;
    logic signed [DW:0]    w_diff;
    logic signed [DW:0]    w_abs;
    logic signed [DW:0]    w_sum;
    logic signed [DW-1:0]  w_next;

    assign w_sp_x   = {r_sp[DW-1], r_sp};
    assign w_tgt_x  = {r_target[DW-1], r_target};
    assign w_step_x = $signed({1'b0, r_step});
    assign w_diff   = w_tgt_x - w_sp_x;
    assign w_abs    = w_diff[DW] ? -w_diff : w_diff;
    assign w_sum    = w_diff[DW] ? (w_sp_x - w_step_x) : (w_sp_x + w_step_x);

    // The moved value always lies between sp and target, so dropping the
    // extra bit is lossless.
    always_comb begin
        w_next = w_sum[DW-1:0];
        if ((r_step == '0) || (w_abs <= w_step_x)) begin
            w_next = r_target;
        end
    end

    sys_bus_wr_master #(
        .TMO (TMO)
    ) u_wr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (w_req),
        .addr_i (w_req_addr),
        .data_i (w_req_data),
        .done_o (w_wr_done),
        .err_o  (w_wr_err),
        .bus    (bus)
    );

    // Next-state and write-request logic. Requests are issued on the edge
    // that enters a write state, so the strobe lines up with its first cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_req       = 1'b0;
        w_req_addr  = SP_ADDR;
        w_req_data  = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start_i) begin
                    w_start_acc = 1'b1;
                    if (irst_i) begin
                        w_req       = 1'b1;
                        w_req_addr  = CFG_ADDR;
                        w_req_data  = IRST_MASK;
                        w_state_nxt = ST_IRST_SET;
                    end else begin
                        w_state_nxt = ST_STEP;
                    end
                end
            end
            ST_IRST_SET: begin
                if (w_wr_err) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr_done) begin
                    w_req       = 1'b1;
                    w_req_addr  = CFG_ADDR;
                    w_req_data  = '0;
                    w_state_nxt = ST_IRST_CLR;
                end
            end
            // Set/clear are one unit: an abort never leaves integrators held.
            ST_IRST_CLR: begin
                if (w_wr_err) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr_done) begin
                    w_state_nxt = abort_i ? ST_DONE : ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_req       = 1'b1;
                    w_req_addr  = SP_ADDR;
                    w_req_data  = {{(32-DW){w_next[DW-1]}}, w_next};
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_wr_err) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr_done) begin
                    w_state_nxt = (abort_i || (r_next == r_target)) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    w_state_nxt = ST_DONE;
                end else if (r_wait_cnt == 32'd0) begin
                    w_state_nxt = ST_STEP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_sp       <= '0;
            r_next     <= '0;
            r_step     <= '0;
            r_interval <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start_acc) begin
                r_target   <= target_i;
                r_step     <= step_i;
                r_interval <= interval_i;
                r_err      <= 1'b0;
            end

            if ((r_state == ST_IRST_SET || r_state == ST_IRST_CLR || r_state == ST_WRITE)
                && w_wr_err) begin
                r_err <= 1'b1;
            end

            if (r_state == ST_STEP) begin
                r_next <= w_next;
            end

            if ((r_state == ST_WRITE) && w_wr_done) begin
                r_sp <= r_next;
            end

            // Interval 0 behaves as 1: WAIT always lasts at least one cycle.
            if (w_state_nxt == ST_WAIT && r_state != ST_WAIT) begin
                r_wait_cnt <= (r_interval == 32'd0) ? 32'd0 : (r_interval - 32'd1);
            end else if (r_state == ST_WAIT && r_wait_cnt != 32'd0) begin
                r_wait_cnt <= r_wait_cnt - 32'd1;
            end
        end
    end

    assign busy_o = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o = (r_state == ST_DONE);
    assign err_o  = r_err;
    assign sp_o   = r_sp;

endmodule

// File: tb/tb_pid_setpoint_ramper.sv
// Directed bench for pid_setpoint_ramper: ramps, clamp, integrator reset,
// abort, bus error, ack timeout and mid-ramp reset, with a simple ack model.
module tb_pid_setpoint_ramper;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [13:0] target;
    logic [13:0] step;
    logic [31:0] interval;
    logic        irst;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] sp;

    pid_setpoint_ramper_if bus ();

    pid_setpoint_ramper #(
        .DW  (14),
        .TMO (16)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .abort_i    (abort),
        .target_i   (target),
        .step_i     (step),
        .interval_i (interval),
        .irst_i     (irst),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .sp_o       (sp),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave model: ack (or err) ack_dly cycles after the strobe cycle.
    int          ack_dly      = 2;
    bit          suppress_ack = 0;
    int          err_at_write = -1;
    int          pend_cnt     = -1;
    bit          pend_err     = 0;
    int          wr_count     = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cnt     = 0;

    initial begin
        bus.sys_ack_i = 1'b0;
        bus.sys_err_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.sys_ack_i = 1'b0;
            bus.sys_err_i = 1'b0;
            if (done) done_cnt++;
            if (bus.sys_wen_o) begin
                wr_addr_q.push_back(bus.sys_addr_o);
                wr_data_q.push_back(bus.sys_wdata_o);
                wr_cyc_q.push_back(cyc);
                pend_cnt = ack_dly;
                pend_err = (wr_count == err_at_write);
                wr_count++;
            end
            if (pend_cnt == 0) begin
                if (!suppress_ack) begin
                    if (pend_err) bus.sys_err_i = 1'b1;
                    else          bus.sys_ack_i = 1'b1;
                end
                pend_cnt = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
        end
    end

    task automatic clr_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_count = 0;
        done_cnt = 0;
    endtask

    // Pulses start for one cycle; returns the cycle number right after the start edge.
    task automatic do_start(input int tgt, input int stp, input int ivl, input bit irs,
                            output int t0);
        target   = 14'(tgt);
        step     = 14'(stp);
        interval = 32'(ivl);
        irst     = irs;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        t0       = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_writes(input string tag, input logic [31:0] addr[$], input int data[$]);
        chk({tag, "_cnt"}, 32'(wr_addr_q.size()), 32'(addr.size()));
        for (int i = 0; i < addr.size() && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], addr[i]);
            chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], 32'(data[i]));
        end
    endtask

    initial begin
        int t0;
        int n;
        int err_cyc;
        logic [31:0] a_q[$];
        int          d_q[$];

        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        target = '0; step = '0; interval = '0; irst = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset state
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_wen",   {31'd0, bus.sys_wen_o}, 32'd0);
        chk("rst_ren",   {31'd0, bus.sys_ren_o}, 32'd0);
        chk("rst_sp",    {18'd0, sp}, 32'd0);
        chk("rst_addr",  bus.sys_addr_o, 32'd0);
        chk("rst_wdata", bus.sys_wdata_o, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Up-ramp 0 -> 7000 by 1000, interval 10; ack latency 3 cycles -> spacing 14
        clr_log();
        do_start(7000, 1000, 10, 0, t0);
        chk("up_busy", {31'd0, busy}, 32'd1);
        wait_idle(400);
        a_q = '{7{32'h10}};
        d_q = '{1000, 2000, 3000, 4000, 5000, 6000, 7000};
        chk_writes("up", a_q, d_q);
        if (wr_cyc_q.size() == 7) begin
            chk("up_first", 32'(wr_cyc_q[0]), 32'(t0 + 1));
            for (int i = 1; i < 7; i++)
                chk($sformatf("up_space%0d", i), 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd14);
        end
        chk("up_done", 32'(done_cnt), 32'd1);
        chk("up_sp", {18'd0, sp}, 32'd7000);

        // Down-ramp with clamp, interval 0 -> spacing 3 + 2 = 5
        clr_log();
        do_start(-2500, 3000, 0, 0, t0);
        wait_idle(200);
        a_q = '{4{32'h10}};
        d_q = '{4000, 1000, -2000, -2500};
        chk_writes("dn", a_q, d_q);
        if (wr_cyc_q.size() >= 2)
            chk("dn_space", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd5);
        chk("dn_sp", {{18{sp[13]}}, sp}, 32'hFFFF_F63C);
        chk("dn_done", 32'(done_cnt), 32'd1);

        // Integrator reset then jump to 500
        clr_log();
        do_start(500, 0, 5, 1, t0);
        wait_idle(200);
        a_q = '{32'h0, 32'h0, 32'h10};
        d_q = '{14, 0, 500};
        chk_writes("irst", a_q, d_q);
        if (wr_cyc_q.size() >= 1)
            chk("irst_first", 32'(wr_cyc_q[0]), 32'(t0));
        chk("irst_sp", {18'd0, sp}, 32'd500);

        // Return to 0, then abort a 0 -> 7000 ramp in WAIT after 3000 acked
        do_start(0, 0, 1, 0, t0);
        wait_idle(100);
        clr_log();
        do_start(7000, 1000, 10, 0, t0);
        n = 0;
        while (sp != 14'd3000 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ab_reach", {18'd0, sp}, 32'd3000);
        abort = 1'b1;
        wait_idle(100);
        abort = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("ab_writes", 32'(wr_count), 32'd3);
        chk("ab_done", 32'(done_cnt), 32'd1);
        chk("ab_sp", {18'd0, sp}, 32'd3000);

        // Bus error on the second write
        clr_log();
        err_at_write = 1;
        do_start(5000, 1000, 2, 0, t0);
        wait_idle(200);
        err_at_write = -1;
        chk("er_err", {31'd0, err}, 32'd1);
        chk("er_busy", {31'd0, busy}, 32'd0);
        chk("er_done", 32'(done_cnt), 32'd0);
        chk("er_writes", 32'(wr_count), 32'd2);
        chk("er_sp", {18'd0, sp}, 32'd4000);
        do_start(5000, 1000, 2, 0, t0);
        chk("er_clear", {31'd0, err}, 32'd0);
        wait_idle(100);
        chk("er_sp2", {18'd0, sp}, 32'd5000);

        // Ack timeout, TMO = 16
        clr_log();
        suppress_ack = 1;
        do_start(6000, 0, 1, 0, t0);
        n = 0;
        while (!err && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        err_cyc = cyc;
        chk("to_err", {31'd0, err}, 32'd1);
        if (wr_cyc_q.size() >= 1)
            chk("to_delay", 32'(err_cyc - wr_cyc_q[0]), 32'd16);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_sp", {18'd0, sp}, 32'd5000);
        suppress_ack = 0;
        @(posedge clk); #1;

        // Reset mid-ramp
        do_start(-7000, 500, 20, 0, t0);
        repeat (40) @(posedge clk); #1;
        chk("mr_busy_pre", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_err", {31'd0, err}, 32'd0);
        chk("mr_wen", {31'd0, bus.sys_wen_o}, 32'd0);
        chk("mr_sp", {18'd0, sp}, 32'd0);
        chk("mr_addr", bus.sys_addr_o, 32'd0);
        chk("mr_wdata", bus.sys_wdata_o, 32'd0);
        pend_cnt = -1;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
